// File: rtl/wr_pg_bndry_checker.sv
// Write page-boundary checker for the octal DDR controller.
// Pops one 16-bit beat per cycle from TX_DQ_FIFO while a write transfer is
// active, tracks the address of the next beat to drive, and splits an INCR
// write at the programmed page boundary or when the FIFO runs dry. On a split
// the resume address and remaining beat count are held for the data shifter.
module wr_pg_bndry_checker #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int DQS_CNT_WIDTH  = (AXI_DATA_WIDTH == 32) ? 10 :
                                   (AXI_DATA_WIDTH == 64) ? 11 : 12
) (
    input  logic                      mem_clk,
    input  logic                      rst_n,
    input  logic [3:0]                mem_page_size,
    input  logic                      start_track,
    input  logic                      stop_write,
    input  logic                      wr_rd,
    input  logic [AXI_ADDR_WIDTH-1:0] first_addr,
    input  logic [1:0]                xfer_btype,
    input  logic [DQS_CNT_WIDTH-1:0]  xfer_mem_len,
    input  logic                      tx_dq_fifo_empty,
    output logic                      tx_dq_fifo_rd_en,
    output logic                      dq_oe,
    output logic                      wr_pg_bndry_expired,
    output logic                      wr_underrun,
    output logic                      wr_done,
    output logic [AXI_ADDR_WIDTH-1:0] wr_last_addr,
    output logic [DQS_CNT_WIDTH-1:0]  wr_rem_len
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SPLIT  = 2'd2
    } state_t;

    localparam logic [1:0] BTYPE_WRAP = 2'b10;

    state_t                      state_q, state_d;
    logic                        dq_oe_q, dq_oe_d;
    logic                        pg_exp_q, pg_exp_d;
    logic                        underrun_q, underrun_d;
    logic                        done_q, done_d;
    logic [AXI_ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
    logic [DQS_CNT_WIDTH-1:0]    rem_len_q, rem_len_d;
    // Wrap window captured at start: enable plus (window bytes - 1).
    logic                        wrap_en_q, wrap_en_d;
    logic [5:0]                  wrap_mask_q, wrap_mask_d;

    logic [AXI_ADDR_WIDTH-1:0]   addr_inc;
    logic [AXI_ADDR_WIDTH-1:0]   wrap_mask_ext;
    logic [AXI_ADDR_WIDTH-1:0]   next_addr;
    logic [AXI_ADDR_WIDTH-1:0]   pg_mask;
    logic                        pg_split_en;
    logic                        pg_hit;
    logic [DQS_CNT_WIDTH-1:0]    rem_dec;

    // A beat leaves the FIFO only while actively tracking and not being stopped.
    assign tx_dq_fifo_rd_en = (state_q == ST_ACTIVE) & ~tx_dq_fifo_empty & ~stop_write;

    // Next-beat address, page-boundary detection and remaining-length decrement.
    always_comb begin
        addr_inc      = last_addr_q + AXI_ADDR_WIDTH'(2);
        wrap_mask_ext = {{(AXI_ADDR_WIDTH-6){1'b0}}, wrap_mask_q};
        if (wrap_en_q) begin
            next_addr = (last_addr_q & ~wrap_mask_ext) | (addr_inc & wrap_mask_ext);
        end else begin
            next_addr = addr_inc;
        end
        // Page sizes below 64 B are not legal and disable splitting.
        pg_split_en = (mem_page_size >= 4'd6);
        pg_mask     = ~({AXI_ADDR_WIDTH{1'b1}} << mem_page_size);
        pg_hit      = pg_split_en & ~wrap_en_q & ((next_addr & pg_mask) == '0);
        rem_dec     = rem_len_q - DQS_CNT_WIDTH'(1);
    end

    // Next-state and next-output decode; stop_write overrides everything else.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can
        // leave it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        dq_oe_d     = dq_oe_q;
        pg_exp_d    = pg_exp_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        last_addr_d = last_addr_q;
        rem_len_d   = rem_len_q;
        wrap_en_d   = wrap_en_q;
        wrap_mask_d = wrap_mask_q;

        if (stop_write) begin
            // Address and length are held so the shifter can sample them.
            state_d    = ST_IDLE;
            dq_oe_d    = 1'b0;
            pg_exp_d   = 1'b0;
            underrun_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_track && wr_rd) begin
                        state_d     = ST_ACTIVE;
                        dq_oe_d     = 1'b1;
                        pg_exp_d    = 1'b0;
                        underrun_d  = 1'b0;
                        last_addr_d = first_addr;
                        rem_len_d   = xfer_mem_len;
                        wrap_en_d   = 1'b0;
                        wrap_mask_d = 6'h00;
                        // Only 8/16/32-beat WRAPs wrap; other lengths run as INCR.
                        if (xfer_btype == BTYPE_WRAP) begin
                            if (xfer_mem_len == DQS_CNT_WIDTH'(8)) begin
                                wrap_en_d   = 1'b1;
                                wrap_mask_d = 6'h0F;
                            end else if (xfer_mem_len == DQS_CNT_WIDTH'(16)) begin
                                wrap_en_d   = 1'b1;
                                wrap_mask_d = 6'h1F;
                            end else if (xfer_mem_len == DQS_CNT_WIDTH'(32)) begin
                                wrap_en_d   = 1'b1;
                                wrap_mask_d = 6'h3F;
                            end
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!tx_dq_fifo_empty) begin
                        last_addr_d = next_addr;
                        rem_len_d   = rem_dec;
                        // Completion wins over a boundary hit on the last beat.
                        if (rem_dec == '0) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            dq_oe_d = 1'b0;
                        end else if (pg_hit) begin
                            state_d  = ST_SPLIT;
                            pg_exp_d = 1'b1;
                            dq_oe_d  = 1'b0;
                        end
                    end else begin
                        state_d    = ST_SPLIT;
                        underrun_d = 1'b1;
                        dq_oe_d    = 1'b0;
                    end
                end
                ST_SPLIT: begin
                    // Hold everything until the shifter acknowledges with stop_write.
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge mem_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the values from before this edge, independent of statement order.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dq_oe_q     <= 1'b0;
            pg_exp_q    <= 1'b0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
            last_addr_q <= '0;
            rem_len_q   <= '0;
            wrap_en_q   <= 1'b0;
            wrap_mask_q <= 6'h00;
        end else begin
            state_q     <= state_d;
            dq_oe_q     <= dq_oe_d;
            pg_exp_q    <= pg_exp_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
            last_addr_q <= last_addr_d;
            rem_len_q   <= rem_len_d;
            wrap_en_q   <= wrap_en_d;
            wrap_mask_q <= wrap_mask_d;
        end
    end

    assign dq_oe               = dq_oe_q;
    assign wr_pg_bndry_expired = pg_exp_q;
    assign wr_underrun         = underrun_q;
    assign wr_done             = done_q;
    assign wr_last_addr        = last_addr_q;
    assign wr_rem_len          = rem_len_q;

endmodule
